// File: rtl/mux_pipe_reg.sv
// NUM_IN:1 channel select registered behind a valid/ready handshake with a 2-entry skid buffer.
// Out-of-range selects are flagged on out_err and carry zero data.
module mux_pipe_reg #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    // Encoding is {out_valid, skid_valid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] skid_data;
    logic             skid_err;
    logic [WIDTH-1:0] cap_data;
    logic             cap_err;
    logic             accept;
    logic             pop;

    assign out_valid = state[1];
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Any select not matched by a channel leaves zero data with err set.
    always_comb begin
        cap_data = '0;
        cap_err  = 1'b1;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                cap_data = in_data[int'(k)*WIDTH +: WIDTH];
                cap_err  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            out_data  <= '0;
            out_err   <= 1'b0;
            skid_data <= '0;
            skid_err  <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_data <= cap_data;
                        out_err  <= cap_err;
                        state    <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        out_data <= cap_data;
                        out_err  <= cap_err;
                    end else if (accept) begin
                        skid_data <= cap_data;
                        skid_err  <= cap_err;
                        state     <= FULL;
                        in_ready  <= 1'b0;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        out_data <= skid_data;
                        out_err  <= skid_err;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_pipe_reg.sv
// Directed bench for mux_pipe_reg: an occupancy model plus expected-item queue, checked by a
// negedge monitor that compares the head item on every cycle the DUT holds one.
module tb_mux_pipe_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] in_data;
    logic [1:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] out_data;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;

    mux_pipe_reg #(.WIDTH(32), .NUM_IN(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } item_t;

    item_t       exp_q[$];
    int          occ       = 0;
    logic        mdl_ready = 1'b1;
    logic        last_acc  = 1'b0;
    logic [31:0] cur_d     = '0;
    logic        cur_e     = 1'b0;
    int          n_tests   = 0;
    int          n_fail    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accept/pop bookkeeping at each rising edge.
    initial begin
        logic acc;
        logic pp;
        forever begin
            @(posedge clk);
            acc = in_valid && mdl_ready;
            pp  = (occ > 0) && out_ready;
            if (rst) begin
                occ = 0; exp_q.delete(); mdl_ready = 1'b1; last_acc = 1'b0;
            end else if (flush) begin
                occ = 0; exp_q.delete(); mdl_ready = 1'b1; last_acc = acc;
            end else begin
                if (acc) exp_q.push_back('{data: cur_d, err: cur_e});
                occ = occ + int'(acc) - int'(pp);
                mdl_ready = (occ < 2);
                last_acc  = acc;
            end
        end
    end

    // Monitor: compare handshake state and head item; pop on a transfer.
    initial begin
        item_t h;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("in_ready", 32'(in_ready), 32'(mdl_ready));
                chk("out_valid", 32'(out_valid), 32'(occ > 0));
                if (occ > 0) begin
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL queue: got empty expected item at %0t", $time);
                    end else begin
                        h = exp_q[0];
                        chk("out_data", out_data, h.data);
                        chk("out_err", 32'(out_err), 32'(h.err));
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic send(input logic [1:0] s, input logic [31:0] d, input logic e);
        int unsigned n = 0;
        sel = s; cur_d = d; cur_e = e; in_valid = 1'b1;
        do begin
            @(posedge clk); #1; n++;
        end while (!last_acc && n < 20);
        if (!last_acc) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
        end
    endtask

    task automatic idle(input int unsigned n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; sel = '0; out_ready = 1'b1;
        in_data = {32'h33333333, 32'h22222222, 32'h11111111};
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_out_err", 32'(out_err), 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;

        // Streaming with downstream always ready
        send(2'd1, 32'h22222222, 1'b0);
        send(2'd0, 32'h11111111, 1'b0);
        send(2'd2, 32'h33333333, 1'b0);
        send(2'd1, 32'h22222222, 1'b0);
        idle(3);

        // Backpressure into FULL, stall, then drain
        out_ready = 1'b0;
        send(2'd0, 32'h11111111, 1'b0);
        send(2'd2, 32'h33333333, 1'b0);
        idle(5);
        out_ready = 1'b1;
        idle(4);

        // Out-of-range select, then back in range; sel = NUM_IN-1 is legal
        send(2'd3, 32'h00000000, 1'b1);
        send(2'd0, 32'h11111111, 1'b0);
        send(2'd2, 32'h33333333, 1'b0);
        idle(3);

        // Different channel contents
        in_data = {32'hCAFEF00D, 32'h0BADBEEF, 32'hDEADBEEF};
        send(2'd2, 32'hCAFEF00D, 1'b0);
        send(2'd0, 32'hDEADBEEF, 1'b0);
        send(2'd1, 32'h0BADBEEF, 1'b0);
        idle(3);
        in_data = {32'h33333333, 32'h22222222, 32'h11111111};

        // Flush while FULL with a third item offered
        out_ready = 1'b0;
        send(2'd0, 32'h11111111, 1'b0);
        send(2'd1, 32'h22222222, 1'b0);
        sel = 2'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        idle(2);
        out_ready = 1'b1;
        idle(3);

        // Flush in ONE with a concurrent accept and pop
        send(2'd1, 32'h22222222, 1'b0);
        sel = 2'd0; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        idle(3);

        // Synchronous reset while FULL
        out_ready = 1'b0;
        send(2'd2, 32'h33333333, 1'b0);
        send(2'd1, 32'h22222222, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_out_valid", 32'(out_valid), 32'h0);
        chk("midreset_out_data", out_data, 32'h0);
        chk("midreset_out_err", 32'(out_err), 32'h0);
        chk("midreset_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;

        // Reset pulse between edges must not disturb a held item
        send(2'd3, 32'h00000000, 1'b1);
        in_valid = 1'b0;
        rst = 1'b1;
        #3 rst = 1'b0;
        idle(2);
        out_ready = 1'b1;
        idle(3);

        chk("drain_queue", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
